ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Shares the single 8-bit data RAM between NREQ requesters: core controller, loader, debug port, etc.
//  Performs req/gnt arbitration, muxes address and write data onto the RAM port, and returns read data with a valid strobe.
//  Sits between the requesters and the RAM, and owns ram_ena/ram_read/ram_write.
// PARAMETERS
//  NREQ      4   number of requesters (2..8)
//  AW        8   address width
//  DW        8   data width
//  MAX_HOLD  8   max consecutive accesses by one owner before forced re-arbitration (1..255)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous reset, active-low
//  req        in   NREQ     per-requester access request, level
//  wr         in   NREQ     per-requester direction: 1 = write, 0 = read
//  addr_in    in   NREQ*AW  flattened addresses; requester i at [i*AW +: AW]
//  wdata_in   in   NREQ*DW  flattened write data, same packing
//  gnt        out  NREQ     one-hot grant (registered)
//  rdata      out  DW       read data returned to the owner
//  rvalid     out  1        rdata valid for 1 cycle
//  ram_ena    out  1        RAM enable
//  ram_read   out  1        RAM read strobe
//  ram_write  out  1        RAM write strobe
//  ram_addr   out  AW       RAM address
//  ram_wdata  out  DW       RAM write data
//  ram_rdata  in   DW       RAM read data (combinational from ram_addr)
// BEHAVIOUR
//  Reset (rst == 0 at clk edge):
//   - state = IDLE; gnt = 0; rvalid = 0; rdata = 0; ram_* strobes = 0; ram_addr = 0; ram_wdata = 0.
//   - hold_cnt = 0; rr_ptr = 0.
//   - Reset mid-access aborts the access; no rvalid is produced.
//  FSM states IDLE, OWN:
//   - IDLE: if any req, pick winner w and go to OWN with gnt = 1<<w on the next edge; else stay.
//   - OWN, req[owner] == 1 and hold_cnt < MAX_HOLD-1: stay; hold_cnt++.
//   - OWN, req[owner] == 0, or hold_cnt == MAX_HOLD-1:
//     - rr_ptr = owner+1, wrapping NREQ-1 -> 0; hold_cnt = 0.
//     - If another req exists, re-arbitrate and grant directly (no IDLE bubble); else go to IDLE with gnt = 0.
//     - If the owner alone still requests after MAX_HOLD, it is re-granted.
//  Access:
//   - While in OWN with req[owner] == 1, each cycle is one access.
//   - ram_ena = 1; ram_read = ~wr[owner]; ram_write = wr[owner].
//   - ram_addr / ram_wdata come from the owner's slice; all are combinational from registered gnt.
//   - Read: rdata <= ram_rdata and rvalid <= 1 on the edge ending the access cycle.
//  Latency: req rise at edge N -> gnt at N+1 -> RAM access in cycle N+1 -> rvalid at N+2.
//  Requester rules:
//   - A requester must hold req, wr and addr stable until it sees gnt.
//   - Dropping req ends ownership at the next edge; no access occurs in that cycle.
//  Round robin: search starts at rr_ptr, ascending and wrapping; the first set req wins.
//  Simultaneous requests are resolved only by the search order; the grant is always one-hot or zero.
//  ram_read and ram_write are never both 1.
// CONFIGURATION
//  RAM_ARB_FIXED_PRIO_EN defined:
//   - Picker ignores rr_ptr; the lowest index wins.
//   - MAX_HOLD is still enforced, but the owner is re-granted if it is still the lowest requester.
//  RAM_ARB_FIXED_PRIO_EN undefined: round robin as above (default).
// STRUCTURE
//  Package ram_arb_pkg:
//   - state encoding (IDLE = 1'b0, OWN = 1'b1); NREQ_MAX = 8.
//   - function for the pointer increment with wrap.
//  Sub-module rr_picker:
//   - combinational; inputs req and start pointer.
//   - outputs one-hot win and win_idx, plus any flag.
//   - used by both arbitration paths.
// TESTING
//  1. Reset: rst = 0 for 2 cycles with req = 4'hF -> gnt = 0, rvalid = 0, ram_ena = 0 throughout.
//  2. Single read: req[2] = 1, wr = 0, addr = 8'h3C, ram holds 8'hA5.
//     -> gnt = 4'b0100 at N+1, ram_read = 1, ram_addr = 8'h3C.
//     -> rvalid = 1, rdata = 8'hA5 at N+2.
//  3. Round robin: req = 4'hF held; MAX_HOLD = 2.
//     -> gnt sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001.
//  4. Hold limit: only req[1] held for 10 cycles, MAX_HOLD = 8.
//     -> gnt stays 4'b0010 continuously (re-granted); hold_cnt wraps at 7.
//  5. Write and early release: req[3] write addr 8'h10, data 8'h5A for 1 cycle, then req[3] = 0, req[0] = 1.
//     -> ram_write = 1, ram_wdata = 8'h5A once.
//     -> gnt moves to 4'b0001 next edge with no IDLE cycle.
//  6. Mid-access reset: rst = 0 during a read in OWN.
//     -> next edge gnt = 0, rvalid = 0, ram_ena = 0, state IDLE.
//  7. RAM_ARB_FIXED_PRIO_EN build: req = 4'b1010 held -> gnt always 4'b0010.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM arbiter: FSM state encoding and the
// wrapping round-robin pointer increment.
package ram_arb_pkg;

    localparam int NREQ_MAX = 8;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Next requester index after p, wrapping n-1 back to 0.
    function automatic int ptr_inc(input int p, input int n);
        return (p >= n - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority picker: scans req upward from start,
// wrapping, and reports the first set bit as a one-hot win and an index.
import ram_arb_pkg::*;

module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  win,
    output logic [IW-1:0] win_idx,
    output logic          any
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        for (int k = 0; k < NREQ_MAX; k++) begin
            if (k < N) begin
                int            idx;
                logic [IW-1:0] sel;
                idx = (int'(start) + k) % N;
                sel = IW'(idx);
                if (!any && req[sel]) begin
                    any      = 1'b1;
                    win[sel] = 1'b1;
                    win_idx  = sel;
                end
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates NREQ requesters onto one RAM port with a bounded hold time.
// Define RAM_ARB_FIXED_PRIO_EN for lowest-index-wins instead of round robin.
import ram_arb_pkg::*;

module ram_arbiter #(
    parameter int NREQ     = 4,
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  wr,
    input  logic [NREQ*AW-1:0] addr_in,
    input  logic [NREQ*DW-1:0] wdata_in,
    output logic [NREQ-1:0]  gnt,
    output logic [DW-1:0]    rdata,
    output logic             rvalid,
    output logic             ram_ena,
    output logic             ram_read,
    output logic             ram_write,
    output logic [AW-1:0]    ram_addr,
    output logic [DW-1:0]    ram_wdata,
    input  logic [DW-1:0]    ram_rdata
);

    localparam int          IW        = $clog2(NREQ);
    localparam logic [7:0]  HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t          state, state_nx;
    logic [NREQ-1:0] gnt_nx;
    logic [IW-1:0]   owner, owner_nx;
    logic [IW-1:0]   rr_ptr, rr_nx;
    logic [7:0]      hold_cnt, hold_nx;

    logic [AW-1:0]   addr_arr  [NREQ];
    logic [DW-1:0]   wdata_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i]  = addr_in[i*AW +: AW];
        assign wdata_arr[i] = wdata_in[i*DW +: DW];
    end

    logic [IW-1:0]   idle_start, own_start;
    logic [NREQ-1:0] idle_win, own_win;
    logic [IW-1:0]   idle_idx, own_idx;
    logic            idle_any, own_any;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign idle_start = '0;
    assign own_start  = '0;
`else
    // On release the search begins just past the outgoing owner, so a lone
    // owner that hits the hold limit wraps around and wins again.
    assign idle_start = rr_ptr;
    assign own_start  = IW'(ptr_inc(int'(owner), NREQ));
`endif

    rr_picker #(.N(NREQ), .IW(IW)) u_idle_pick (
        .req     (req),
        .start   (idle_start),
        .win     (idle_win),
        .win_idx (idle_idx),
        .any     (idle_any)
    );

    rr_picker #(.N(NREQ), .IW(IW)) u_own_pick (
        .req     (req),
        .start   (own_start),
        .win     (own_win),
        .win_idx (own_idx),
        .any     (own_any)
    );

    logic access, rd_access;

    assign access    = (state == OWN) && req[owner];
    assign rd_access = access && !wr[owner];

    assign ram_ena   = access;
    assign ram_read  = rd_access;
    assign ram_write = access && wr[owner];
    assign ram_addr  = access ? addr_arr[owner]  : '0;
    assign ram_wdata = access ? wdata_arr[owner] : '0;

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        owner_nx = owner;
        hold_nx  = hold_cnt;
        rr_nx    = rr_ptr;
        unique case (state)
            IDLE: begin
                if (idle_any) begin
                    state_nx = OWN;
                    gnt_nx   = idle_win;
                    owner_nx = idle_idx;
                    hold_nx  = '0;
                end
            end
            OWN: begin
                if (req[owner] && (hold_cnt < HOLD_LAST)) begin
                    hold_nx = hold_cnt + 8'd1;
                end else begin
                    rr_nx   = IW'(ptr_inc(int'(owner), NREQ));
                    hold_nx = '0;
                    if (own_any) begin
                        gnt_nx   = own_win;
                        owner_nx = own_idx;
                    end else begin
                        state_nx = IDLE;
                        gnt_nx   = '0;
                        owner_nx = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            rvalid   <= 1'b0;
            rdata    <= '0;
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            owner    <= owner_nx;
            rr_ptr   <= rr_nx;
            hold_cnt <= hold_nx;
            rvalid   <= rd_access;
            if (rd_access) rdata <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one instance at MAX_HOLD=8, one at MAX_HOLD=2,
// sharing stimulus; expected values are hand-derived per step.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, wr;
    logic [31:0] addr_in, wdata_in;

    logic [3:0]  gnt, gnt_h2;
    logic [7:0]  rdata, rdata_h2;
    logic        rvalid, rvalid_h2;
    logic        ram_ena, ram_ena_h2;
    logic        ram_read, ram_read_h2;
    logic        ram_write, ram_write_h2;
    logic [7:0]  ram_addr, ram_addr_h2;
    logic [7:0]  ram_wdata, ram_wdata_h2;
    logic [7:0]  ram_rdata, ram_rdata_h2;

    logic [7:0]  mem [256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign ram_rdata    = mem[ram_addr];
    assign ram_rdata_h2 = mem[ram_addr_h2];

    ram_arbiter #(.NREQ(4), .AW(8), .DW(8), .MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .gnt(gnt), .rdata(rdata), .rvalid(rvalid),
        .ram_ena(ram_ena), .ram_read(ram_read), .ram_write(ram_write),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    ram_arbiter #(.NREQ(4), .AW(8), .DW(8), .MAX_HOLD(2)) dut_h2 (
        .clk(clk), .rst(rst), .req(req), .wr(wr),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .gnt(gnt_h2), .rdata(rdata_h2), .rvalid(rvalid_h2),
        .ram_ena(ram_ena_h2), .ram_read(ram_read_h2), .ram_write(ram_write_h2),
        .ram_addr(ram_addr_h2), .ram_wdata(ram_wdata_h2), .ram_rdata(ram_rdata_h2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] seq_h2 [9];
        logic [3:0] rr_h2  [6];
        seq_h2 = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                   4'b0100, 4'b1000, 4'b1000, 4'b0001};
        rr_h2  = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0010, 4'b0010};

        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h3C] = 8'hA5;

        // Reset held with every requester asking
        rst      = 1'b0;
        req      = 4'hF;
        wr       = 4'h0;
        addr_in  = '0;
        wdata_in = '0;
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_gnt",    32'(gnt),     'h0);
            check("rst_rvalid", 32'(rvalid),  'h0);
            check("rst_ena",    32'(ram_ena), 'h0);
            check("rst_gnt_h2", 32'(gnt_h2),  'h0);
        end

        // Single read by requester 2
        rst     = 1'b1;
        req     = 4'b0100;
        addr_in = {8'h00, 8'h3C, 8'h00, 8'h00};
        tick();
        check("rd_gnt",    32'(gnt),       'h4);
        check("rd_read",   32'(ram_read),  'h1);
        check("rd_write",  32'(ram_write), 'h0);
        check("rd_addr",   32'(ram_addr),  'h3C);
        check("rd_rvalid0", 32'(rvalid),   'h0);
        tick();
        check("rd_rvalid", 32'(rvalid),    'h1);
        check("rd_rdata",  32'(rdata),     'hA5);
        req = 4'b0000;
        tick();
        check("rd_release_gnt", 32'(gnt),    'h0);
        check("rd_cancel_rv",   32'(rvalid), 'h0);
        check("rd_idle_ena",    32'(ram_ena),'h0);

        // Round robin with all requesting; reset first to clear rr_ptr
        rst     = 1'b0;
        addr_in = '0;
        tick();
        rst = 1'b1;
        req = 4'hF;
        for (int c = 0; c < 9; c++) begin
            tick();
            check($sformatf("rr_h2_%0d", c), 32'(gnt_h2), 32'(seq_h2[c]));
            check($sformatf("rr_h8_%0d", c), 32'(gnt), (c < 8) ? 'h1 : 'h2);
        end

        // Lone requester 1 is re-granted across the hold limit
        rst = 1'b0;
        req = 4'b0000;
        tick();
        rst = 1'b1;
        req = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("hold_gnt_%0d", c), 32'(gnt),     'h2);
            check($sformatf("hold_ena_%0d", c), 32'(ram_ena), 'h1);
        end

        // Write by requester 3, then hand-off to requester 0 without a bubble
        req      = 4'b1000;
        wr       = 4'b1000;
        addr_in  = {8'h10, 8'h00, 8'h00, 8'h3C};
        wdata_in = {8'h5A, 8'h00, 8'h00, 8'h00};
        tick();
        check("wr_gnt",   32'(gnt),       'h8);
        check("wr_write", 32'(ram_write), 'h1);
        check("wr_read",  32'(ram_read),  'h0);
        check("wr_addr",  32'(ram_addr),  'h10);
        check("wr_wdata", 32'(ram_wdata), 'h5A);
        req = 4'b0001;
        tick();
        check("ho_gnt",    32'(gnt),       'h1);
        check("ho_write",  32'(ram_write), 'h0);
        check("ho_read",   32'(ram_read),  'h1);
        check("ho_rvalid", 32'(rvalid),    'h0);

        // Reset in the middle of requester 0's read
        rst = 1'b0;
        tick();
        check("mid_rst_gnt",    32'(gnt),     'h0);
        check("mid_rst_rvalid", 32'(rvalid),  'h0);
        check("mid_rst_ena",    32'(ram_ena), 'h0);
        check("mid_rst_gnt_h2", 32'(gnt_h2),  'h0);

        // Requesters 1 and 3 both held
        rst = 1'b1;
        req = 4'b1010;
        wr  = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            tick();
`ifdef RAM_ARB_FIXED_PRIO_EN
            check($sformatf("fp_h2_%0d", c), 32'(gnt_h2), 'h2);
            check($sformatf("fp_h8_%0d", c), 32'(gnt),    'h2);
`else
            check($sformatf("pair_h2_%0d", c), 32'(gnt_h2), 32'(rr_h2[c]));
            check($sformatf("pair_h8_%0d", c), 32'(gnt),    'h2);
`endif
            check($sformatf("pair_excl_%0d", c), 32'(ram_read & ram_write), 'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
